// File: rtl/dp_pkg.sv
// Shared definitions for the CU/datapath pair: default widths, ALU opcodes
// and the CU state encoding.
package dp_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_BITS_DEF  = 5;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_PASSB = 4'b1000;
    localparam logic [3:0] OP_HOLD  = 4'b1111;

    typedef enum logic [2:0] {
        CU_RESET      = 3'd0,
        CU_DECODE     = 3'd1,
        CU_EXECUTE    = 3'd2,
        CU_MEM_ACCESS = 3'd3,
        CU_WRITE_BACK = 3'd4
    } cu_state_e;

endpackage

// File: rtl/datapath_unit_data_mem.sv
// Data memory: synchronous read-first read port, write-enabled store,
// whole array cleared by the asynchronous reset.
module data_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Read samples the pre-write contents, so a same-address write is seen one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            rd_q <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/datapath_unit.sv
// Datapath responder to the CU: operand-B mux, registered ALU with flags,
// and a data memory addressed by the registered ALU result.
module datapath_unit
    import dp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  zero_flag,
    output logic                  carry_flag
);

    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] alu_d, alu_q;
    logic                  zero_d, zero_q;
    logic                  carry_d, carry_q;
    logic [DATA_WIDTH-1:0] mem_q;

    assign op_b = sel3 ? offset : operand2;

    // Next ALU value and flags; HOLD keeps everything, carry only moves on ADD/SUB.
    always_comb begin
        sum     = '0;
        alu_d   = alu_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (opcode)
            OP_ADD: begin
                sum     = {1'b0, operand1} + {1'b0, op_b};
                alu_d   = sum[DATA_WIDTH-1:0];
                carry_d = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                sum     = {1'b0, operand1} - {1'b0, op_b};
                alu_d   = sum[DATA_WIDTH-1:0];
                carry_d = sum[DATA_WIDTH];
            end
            OP_AND:   alu_d = operand1 & op_b;
            OP_OR:    alu_d = operand1 | op_b;
            OP_XOR:   alu_d = operand1 ^ op_b;
            OP_NOT:   alu_d = ~operand1;
            OP_SHL:   alu_d = {operand1[DATA_WIDTH-2:0], 1'b0};
            OP_SHR:   alu_d = {1'b0, operand1[DATA_WIDTH-1:1]};
            OP_PASSB: alu_d = op_b;
            OP_HOLD:  alu_d = alu_q;
            default:  alu_d = '0;
        endcase
        if (opcode != OP_HOLD) begin
            zero_d = (alu_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Address comes from last cycle's ALU result, so storeR survives sel3 dropping with w_r.
    data_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_data_mem (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (alu_q[ADDR_BITS-1:0]),
        .we_i    (w_r),
        .wdata_i (operand2),
        .rdata_o (mem_q)
    );

    assign result2    = sel1 ? alu_q : mem_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboard bench for datapath_unit: the driver queues expected result2/flags
// with a target cycle, an independent monitor pops and compares them.
module tb_datapath_unit;
    import dp_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] operand1, operand2, offset;
    logic [3:0] opcode;
    logic       sel1, sel3, w_r;
    logic [7:0] result2;
    logic       zero_flag, carry_flag;

    typedef struct {
        int         when;
        string      name;
        logic [7:0] r;
        logic       z;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Logic-op table: A=C6, operand2=5A, offset=77, carry stays 1 from the preceding borrow.
    logic [3:0] t_op  [8] = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_PASSB, 4'b1010};
    logic       t_s3  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] t_exp [8] = '{8'h42, 8'hDE, 8'h9C, 8'h39, 8'h8C, 8'h63, 8'h77, 8'h00};
    logic       t_z   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    datapath_unit #(
        .DATA_WIDTH (8),
        .ADDR_BITS  (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .operand1   (operand1),
        .operand2   (operand2),
        .offset     (offset),
        .opcode     (opcode),
        .sel1       (sel1),
        .sel3       (sel3),
        .w_r        (w_r),
        .result2    (result2),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] r, input logic z, input logic c);
        checks++;
        if (result2 !== r || zero_flag !== z || carry_flag !== c) begin
            errors++;
            $display("FAIL %s: got result2=%h zero=%b carry=%b, want result2=%h zero=%b carry=%b",
                     name, result2, zero_flag, carry_flag, r, z, c);
        end
    endtask

    task automatic expect_in(input int lat, input string name, input logic [7:0] r,
                             input logic z, input logic c);
        exp_t e;
        e.when = cyc + lat;
        e.name = name;
        e.r    = r;
        e.z    = z;
        e.c    = c;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                         input logic [3:0] op, input logic s1, input logic s3, input logic wr);
        @(posedge clk);
        #2;
        operand1 = a;
        operand2 = b;
        offset   = o;
        opcode   = op;
        sel1     = s1;
        sel3     = s3;
        w_r      = wr;
    endtask

    // Monitor: samples 1 time unit after each edge, before the driver moves inputs.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            begin
                int i;
                i = 0;
                while (i < sb.size()) begin
                    if (sb[i].when == cyc) begin
                        check(sb[i].name, sb[i].r, sb[i].z, sb[i].c);
                        sb.delete(i);
                    end else if (sb[i].when < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL %s: expectation for cycle %0d not sampled, now cycle %0d",
                                 sb[i].name, sb[i].when, cyc);
                        sb.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation reached %0t without finishing, limit 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        operand1 = '0; operand2 = '0; offset = '0;
        opcode = OP_HOLD; sel1 = 1'b1; sel3 = 1'b0; w_r = 1'b0;
        #1;
        check("reset_async", 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        expect_in(1, "reset_hold", 8'h00, 1'b0, 1'b0);

        drive(8'd200, 8'd100, 8'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
        expect_in(1, "add_carry", 8'd44, 1'b0, 1'b1);
        drive(8'd3, 8'd3, 8'd0, OP_SUB, 1'b1, 1'b0, 1'b0);
        expect_in(1, "sub_zero", 8'h00, 1'b1, 1'b0);
        drive(8'd3, 8'd5, 8'd0, OP_SUB, 1'b1, 1'b0, 1'b0);
        expect_in(1, "sub_borrow", 8'hFE, 1'b0, 1'b1);

        for (int k = 0; k < 8; k++) begin
            drive(8'hC6, 8'h5A, 8'h77, t_op[k], 1'b1, t_s3[k], 1'b0);
            expect_in(1, $sformatf("logic_op_%0d", k), t_exp[k], t_z[k], 1'b1);
        end

        // storeR: address 2+3=5, then write A5 with sel3 dropped
        drive(8'd2, 8'h00, 8'd3, OP_ADD, 1'b1, 1'b1, 1'b0);
        expect_in(1, "store_addr_a", 8'h05, 1'b0, 1'b0);
        drive(8'd2, 8'h00, 8'd3, OP_ADD, 1'b1, 1'b1, 1'b0);
        expect_in(1, "store_addr_b", 8'h05, 1'b0, 1'b0);
        drive(8'd2, 8'hA5, 8'd3, OP_ADD, 1'b1, 1'b0, 1'b1);
        expect_in(1, "store_commit", 8'hA7, 1'b0, 1'b0);

        // loadR: address 1+4=5, data two edges later
        drive(8'd1, 8'h00, 8'd4, OP_ADD, 1'b0, 1'b1, 1'b0);
        expect_in(2, "load_a5", 8'hA5, 1'b0, 1'b0);
        @(posedge clk);

        // address wrap: 30+7=37 -> address 5, reload via 250+11 -> 5 with carry
        drive(8'd30, 8'h00, 8'd7, OP_ADD, 1'b1, 1'b1, 1'b0);
        expect_in(1, "wrap_addr_a", 8'd37, 1'b0, 1'b0);
        drive(8'd30, 8'h00, 8'd7, OP_ADD, 1'b1, 1'b1, 1'b0);
        expect_in(1, "wrap_addr_b", 8'd37, 1'b0, 1'b0);
        drive(8'd30, 8'h3C, 8'd7, OP_ADD, 1'b1, 1'b0, 1'b1);
        expect_in(1, "wrap_commit", 8'h5A, 1'b0, 1'b0);
        drive(8'd250, 8'h00, 8'd11, OP_ADD, 1'b0, 1'b1, 1'b0);
        expect_in(2, "wrap_load", 8'h3C, 1'b0, 1'b1);
        @(posedge clk);

        // read-during-write at address 5: 11 then 22, read-first
        drive(8'd5, 8'h11, 8'd0, OP_ADD, 1'b0, 1'b1, 1'b0);
        expect_in(1, "rdw_prev", 8'h3C, 1'b0, 1'b0);
        drive(8'd5, 8'h11, 8'd0, OP_HOLD, 1'b0, 1'b0, 1'b1);
        expect_in(1, "rdw_first", 8'h3C, 1'b0, 1'b0);
        drive(8'd5, 8'h22, 8'd0, OP_HOLD, 1'b0, 1'b0, 1'b1);
        expect_in(1, "rdw_old", 8'h11, 1'b0, 1'b0);
        drive(8'd5, 8'h22, 8'd0, OP_HOLD, 1'b0, 1'b0, 1'b0);
        expect_in(1, "rdw_new", 8'h22, 1'b0, 1'b0);

        // HOLD over changing operands
        drive(8'd255, 8'd2, 8'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
        expect_in(1, "hold_setup", 8'h01, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(8'(k * 40 + 3), 8'(k * 7), 8'(k * 13), OP_HOLD, 1'b1, k[0], 1'b0);
            expect_in(1, $sformatf("hold_%0d", k), 8'h01, 1'b0, 1'b1);
        end

        // mid-cycle reset with a write pending to address 5
        drive(8'd250, 8'h99, 8'd11, OP_ADD, 1'b1, 1'b1, 1'b0);
        expect_in(1, "pre_reset", 8'h05, 1'b0, 1'b1);
        drive(8'd250, 8'h99, 8'd11, OP_HOLD, 1'b1, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("reset_mid", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        w_r = 1'b0;
        drive(8'd250, 8'h00, 8'd11, OP_ADD, 1'b0, 1'b1, 1'b0);
        expect_in(2, "post_reset_load", 8'h00, 1'b0, 1'b1);
        @(posedge clk);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Responder end of the CU control interface. Consumes operand1/operand2/offset/opcode/sel1/sel3/w_r from the CU and returns result2.
- Contains an operand-B mux, a registered ALU with flags, and a 2^ADDR_BITS x DATA_WIDTH data memory. The memory has a synchronous read and a write-enabled store.
- Timed to the CU FSM:
  - std_op: result2 valid 1 clock after operands are stable.
  - loadR: result2 valid 2 clocks after operands are stable.
  - storeR: the write commits on the edge that samples w_r=1.

Parameters:
- DATA_WIDTH, 8, datapath/operand width
- ADDR_BITS, 5, data memory address bits (32 entries)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- operand1  in  DATA_WIDTH  ALU A; base address for loadR/storeR
- operand2  in  DATA_WIDTH  ALU B when sel3=0; store data for storeR
- offset  in  DATA_WIDTH  ALU B when sel3=1
- opcode  in  4  ALU operation
- sel1  in  1  result2 select: 1=ALU register, 0=memory read register
- sel3  in  1  ALU B select: 1=offset, 0=operand2
- w_r  in  1  data memory write enable
- result2  out  DATA_WIDTH  result returned to CU
- zero_flag  out  1  registered: alu_q==0
- carry_flag  out  1  registered carry/borrow of last ADD/SUB

Behaviour:
- Reset (async, rst=1): alu_q, mem_q, zero_flag and carry_flag go to 0. All memory words go to 0. result2 therefore reads 0. Reset asserted mid-operation aborts any pending write.
- B operand: B = sel3 ? offset : operand2 (combinational).
- ALU (registered into alu_q every posedge):
  - 0000 ADD A+B; carry = bit DATA_WIDTH of the sum
  - 0001 SUB A-B; carry = borrow
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT A
  - 0110 A<<1
  - 0111 A>>1 (logical)
  - 1000 pass B
  - 1111 HOLD: alu_q and both flags keep their values (CU reset default)
  - any other opcode: alu_q=0, flags update accordingly
- Arithmetic: results truncate to DATA_WIDTH; wrap-around is silent.
- Flags:
  - zero_flag updates on every non-HOLD opcode.
  - carry_flag updates only on ADD/SUB; otherwise it is held.
- Memory address: addr = alu_q[ADDR_BITS-1:0]. Upper bits are ignored (address wraps modulo 2^ADDR_BITS).
- Read: mem_q <= mem[addr] every posedge (synchronous, unconditional).
- Write: if w_r=1 at a posedge, mem[addr] <= operand2. alu_q still holds the address computed from the previous cycle's inputs. This gives correct storeR even though the CU drops sel3 in the same cycle it raises w_r.
- Read-during-write to the same addr: mem_q gets the OLD data (read-first). The new data is visible on the following edge.
- Output: result2 = sel1 ? alu_q : mem_q (combinational mux of registered values, no added latency).
- Latency from stable inputs:
  - std_op: 1 edge to alu_q, sampled by the CU at WRITE_BACK.
  - loadR: edge 1 computes the address, edge 2 produces mem_q, sampled at WRITE_BACK.
- No handshake: the block is always ready. The CU FSM guarantees operands stay stable through DECODE..WRITE_BACK.
- w_r held high for several cycles writes on every edge (idempotent while inputs are stable).

Decomposition:
- Shared package dp_pkg:
  - opcode localparams (OP_ADD..OP_PASSB, OP_HOLD=4'b1111)
  - DATA_WIDTH/ADDR_BITS defaults
  - CU state encodings (RESET/DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK), reused by the bench
- One sub-module is natural: data_mem (sync read, write enable, async reset clear, read-first). The ALU, flags and muxes stay in the top level.

Test Plan:
- Reset: assert rst mid-cycle with w_r=1 -> result2=0 and flags=0 immediately; memory at address 5 reads 0 afterward; no write occurs.
- ADD: op1=8'd200, op2=8'd100, sel3=0, sel1=1, opcode=0000 -> after 1 edge result2=8'd44, carry_flag=1, zero_flag=0. Then SUB 3-3 -> result2=0, zero_flag=1, carry_flag=0.
- Store/load: storeR with op1=2, offset=3, sel3=1 for 2 cycles, then w_r=1, sel3=0, op2=8'hA5 for 1 edge.
  - Then loadR with op1=1, offset=4, sel3=1, sel1=0 -> result2=8'hA5 two edges later.
  - Address 5 holds A5.
- Address wrap: op1=8'd30, offset=8'd7 (sum 37) -> store hits address 5. A subsequent load of address 5 returns that data.
- Read-during-write: same address, w_r=1 with prior content 8'h11 and new content 8'h22 -> mem_q=8'h11 on that edge, 8'h22 on the next.
- HOLD: opcode=1111 with changing operands -> alu_q and flags unchanged over 4 edges.
